// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// The stage entry is sized for the widest supported configuration; instances use the low bits.
package regfile_write_arbiter_pkg;

    localparam int MAX_ADDR_W = 16;
    localparam int MAX_DATA_W = 128;
    localparam int MAX_SRC_W  = 3;

    function automatic int addr_width(input int length);
        return (length > 2) ? $clog2(length) : 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_SRC_W-1:0]  src;
    } stage_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above ptr, wrapping to 0.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates several writers onto one register-file write port through a single
// output stage that holds its entry while the register file stalls.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LENGTH      = 32,
    parameter int REQUESTERS  = 3,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [REQUESTERS-1:0]                        req_valid,
    input  logic [REQUESTERS-1:0][addr_width(LENGTH)-1:0] req_addr,
    input  logic [REQUESTERS-1:0][WIDTH-1:0]             req_data,
    output logic [REQUESTERS-1:0]                        req_ready,
    input  logic                                         wr_stall,
    output logic                                         wr_enable,
    output logic [addr_width(LENGTH)-1:0]                wr_addr,
    output logic [WIDTH-1:0]                             wr_data,
    output logic [$clog2(REQUESTERS)-1:0]                wr_src,
    output logic                                         drop_pulse
);

    localparam int ADDR_W = addr_width(LENGTH);
    localparam int SRC_W  = $clog2(REQUESTERS);

    logic [SRC_W-1:0]      rr_ptr_p1;
    logic [REQUESTERS-1:0] grant_p0;
    logic [SRC_W-1:0]      win_idx_p0;
    logic                  win_any_p0;
    logic [ADDR_W-1:0]     win_addr_p0;
    logic [WIDTH-1:0]      win_data_p0;
    logic                  accept_p0;
    logic                  xfer_p0;
    logic                  drop_p0;
    stage_entry_t          stage_p1;
    logic                  drop_p1;
    logic                  unused_entry_bits;

    rr_arbiter #(
        .N     (REQUESTERS),
        .IDX_W (SRC_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_p1),
        .grant     (grant_p0),
        .grant_idx (win_idx_p0),
        .grant_any (win_any_p0)
    );

    // Stage p0: select the winner and decide whether it is kept or discarded
    assign win_addr_p0 = req_addr[win_idx_p0];
    assign win_data_p0 = req_data[win_idx_p0];
    assign accept_p0   = !rst && !(stage_p1.valid && wr_stall);
    assign req_ready   = accept_p0 ? grant_p0 : '0;
    assign xfer_p0     = accept_p0 && win_any_p0;

    always_comb begin
        drop_p0 = 1'b0;
        if ((ZERO_REG_EN != 0) && (win_addr_p0 == '0)) drop_p0 = 1'b1;
        if (int'(win_addr_p0) >= LENGTH) drop_p0 = 1'b1;
    end

    // Stage p1: output entry, frozen while the register file stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_p1  <= '0;
            rr_ptr_p1 <= '0;
            drop_p1   <= 1'b0;
        end else begin
            drop_p1 <= xfer_p0 && drop_p0;
            if (xfer_p0) begin
                rr_ptr_p1 <= (win_idx_p0 == SRC_W'(REQUESTERS - 1)) ? '0 : win_idx_p0 + 1'b1;
            end
            if (!(stage_p1.valid && wr_stall)) begin
                if (xfer_p0 && !drop_p0) begin
                    stage_p1.valid <= 1'b1;
                    stage_p1.addr  <= MAX_ADDR_W'(win_addr_p0);
                    stage_p1.data  <= MAX_DATA_W'(win_data_p0);
                    stage_p1.src   <= MAX_SRC_W'(win_idx_p0);
                end else begin
                    stage_p1.valid <= 1'b0;
                end
            end
        end
    end

    assign wr_addr    = stage_p1.addr[ADDR_W-1:0];
    assign wr_data    = stage_p1.data[WIDTH-1:0];
    assign wr_src     = stage_p1.src[SRC_W-1:0];
    // An entry whose address went unknown is suppressed rather than issued
    assign wr_enable  = stage_p1.valid && !wr_stall && !$isunknown(stage_p1.addr[ADDR_W-1:0]);
    assign drop_pulse = drop_p1;

    // Bits of the shared entry beyond this instance's widths are never read
    assign unused_entry_bits = ^stage_p1;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning register data width.
REQ-002 SHALL have parameter LENGTH, default 32, meaning number of architectural registers.
REQ-003 SHALL have parameter REQUESTERS, default 3, meaning number of competing writers (ALU, load, branch-path units); legal range 2..8.
REQ-004 SHALL have parameter ZERO_REG_EN, default 1, meaning writes to register 0 are discarded.
REQ-005 SHALL have port clk, input, 1, meaning the clock.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port req_valid, input, [REQUESTERS] x 1, meaning requester i holds a write.
REQ-008 SHALL have port req_addr, input, [REQUESTERS] x $clog2(LENGTH), meaning target register per requester.
REQ-009 SHALL have port req_data, input, [REQUESTERS] x WIDTH, meaning write data per requester.
REQ-010 SHALL have port req_ready, output, [REQUESTERS] x 1, meaning requester i's write is accepted this cycle.
REQ-011 SHALL have port wr_stall, input, 1, meaning the regfile cannot take a write this cycle.
REQ-012 SHALL have port wr_enable, output, 1, meaning a regfile write is issued this cycle.
REQ-013 SHALL have port wr_addr, output, $clog2(LENGTH), meaning the issued write address.
REQ-014 SHALL have port wr_data, output, WIDTH, meaning the issued write data.
REQ-015 SHALL have port wr_src, output, $clog2(REQUESTERS), meaning the requester index of the issued write.
REQ-016 SHALL have port drop_pulse, output, 1, meaning an accepted write was discarded (x0 or out of range).

Function
REQ-017 SHALL hold one output-stage entry (out_valid, addr, data, src) with states EMPTY (out_valid=0), FULL (out_valid=1, wr_stall=0) and STALLED (out_valid=1, wr_stall=1).
REQ-018 SHALL drive wr_enable = out_valid AND NOT wr_stall, combinationally from state and wr_stall; wr_addr/wr_data/wr_src come from the stage registers.
REQ-019 SHALL accept a new request in a cycle only if the stage is EMPTY or FULL (i.e., not STALLED), giving one write per cycle at full throughput.
REQ-020 SHALL choose the winner by round-robin: lowest index i >= rr_ptr with req_valid[i], wrapping to 0; at most one req_ready bit high per cycle.
REQ-021 SHALL transfer on req_valid[i] AND req_ready[i]; the requester holds valid, addr and data stable until that cycle.
REQ-022 SHALL update rr_ptr to (winner+1) mod REQUESTERS after a transfer, and leave it unchanged in cycles without a transfer.
REQ-023 SHALL write the stage on the clock edge ending a transfer cycle, so an accepted write appears on wr_enable one cycle later (latency 1 with wr_stall low).
REQ-024 SHALL, when no transfer occurs and the stage issues (FULL), go EMPTY at the next edge.
REQ-025 SHALL, in STALLED, hold all stage registers and deassert every req_ready until wr_stall falls.
REQ-026 SHALL accept a request addressed to register 0 when ZERO_REG_EN=1 (ready asserted, rr_ptr advances) but not load the stage, and pulse drop_pulse for one cycle in the following cycle.
REQ-027 SHALL treat req_addr >= LENGTH (non-power-of-2 LENGTH) the same way as REQ-026.
REQ-028 SHALL combinationally drop (not issue) a stage write whose address became undefined; no X shall propagate to wr_enable.

Reset
REQ-029 SHALL, on rst asserted, immediately clear out_valid, rr_ptr to 0 and drop_pulse to 0; stage address/data/src reset to 0.
REQ-030 SHALL discard any pending stage entry when rst asserts mid-operation; wr_enable and all req_ready are 0 while rst is high.

Structure
REQ-031 SHALL place the address-width constant function and the stage-entry struct (valid, addr, data, src) in the shared common package.
REQ-032 SHALL implement arbitration as one sub-module rr_arbiter (REQUESTERS-wide request vector, pointer input, one-hot grant plus index output).

Verification
REQ-033 Single requester: req 1 valid addr 5 data 0xDEAD_BEEF -> ready[1] in cycle 0, wr_enable with addr 5, data 0xDEADBEEF, src 1 in cycle 1.
REQ-034 All three valid continuously with wr_stall low -> grants ordered 0,1,2,0,1,2; one wr_enable per cycle, no gaps.
REQ-035 Stage FULL, wr_stall high 3 cycles -> wr_enable 0, all ready 0, wr_addr/wr_data held; first cycle after stall falls -> wr_enable 1 and a new grant.
REQ-036 Requester 2 writes addr 0 -> ready[2]=1, no wr_enable, drop_pulse=1 next cycle, rr_ptr becomes 0.
REQ-037 rst asserted while STALLED with stage holding addr 7 -> wr_enable 0 immediately; after release with req 0 valid, write to addr 7 never appears and req 0 wins first.
